regfile_alu_seq: RTL and testbench

- Multi-cycle sequencer placed between a command source (test harness or a future decode stage) and the 32x32 register file plus the 32-bit ALU.
- Accepts one register-to-register or load-immediate command per valid/ready handshake.
- For each command it reads the two source registers, presents them to the ALU, latches the result, and writes it back through the register file write port.
- Counts retired commands and reports the ALU zero flag.

---
 rtl/regfile_alu_seq_pkg.sv | 25 ++
 rtl/regfile_alu_seq_if.sv | 25 ++
 rtl/regfile_alu_seq.sv | 123 ++++++++++++
 tb/tb_regfile_alu_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_alu_seq_pkg.sv
// Shared definitions for the register-file/ALU command sequencer.
// Holds the ALU op codes, the FSM states and the register address width.
package regfile_alu_seq_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_NOR = 3'b100,
    OP_SRL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_e;

endpackage

// File: rtl/regfile_alu_seq_if.sv
// Command channel between a command source and the sequencer.
// One command is transferred on each cycle where cmd_valid and cmd_ready are both high.
interface regfile_alu_seq_if;
  import regfile_alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic              cmd_li;
  logic [15:0]       cmd_imm;
  logic [REG_AW-1:0] cmd_rs;
  logic [REG_AW-1:0] cmd_rt;
  logic [REG_AW-1:0] cmd_rd;

  modport master (
    output cmd_valid, cmd_op, cmd_li, cmd_imm, cmd_rs, cmd_rt, cmd_rd,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_li, cmd_imm, cmd_rs, cmd_rt, cmd_rd,
    output cmd_ready
  );

endinterface

// File: rtl/regfile_alu_seq.sv
// Four-state sequencer: read two registers, run the external ALU, write the result back.
// The register file and the ALU live outside this block; it only drives their ports.
module regfile_alu_seq
  import regfile_alu_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_alu_seq_if.slave     cmd,
  output logic [REG_AW-1:0]    R_addr_A,
  output logic [REG_AW-1:0]    R_addr_B,
  output logic [REG_AW-1:0]    Wt_addr,
  output logic [31:0]          Wt_data,
  output logic                 L_S,
  input  logic [31:0]          rdata_A,
  input  logic [31:0]          rdata_B,
  output logic [31:0]          alu_A,
  output logic [31:0]          alu_B,
  output logic [2:0]           alu_op,
  input  logic [31:0]          alu_res,
  input  logic                 alu_zero,
  output logic                 done,
  output logic                 zero_flag,
  output logic [CNT_W-1:0]     retired_cnt
);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic              li_q;
  logic [15:0]       imm_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [31:0]       op_a_q, op_b_q, res_q;
  logic              z_q;

  // Each state's datapath capture happens on the edge that leaves that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      li_q        <= 1'b0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      z_q         <= 1'b0;
      zero_flag   <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q  <= cmd.cmd_op;
            li_q  <= cmd.cmd_li;
            imm_q <= cmd.cmd_imm;
            rs_q  <= cmd.cmd_rs;
            rt_q  <= cmd.cmd_rt;
            rd_q  <= cmd.cmd_rd;
          end
        end
        S_READ: begin
          op_a_q <= rdata_A;
          op_b_q <= rdata_B;
        end
        S_EXEC: begin
          res_q <= li_q ? {16'b0, imm_q} : alu_res;
          z_q   <= alu_zero;
        end
        S_WB: begin
          retired_cnt <= retired_cnt + CNT_W'(1);
          if (!li_q) zero_flag <= z_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs idle at zero and are only driven in the state that owns them.
  always_comb begin
    state_d       = state_q;
    cmd.cmd_ready = 1'b0;
    R_addr_A      = '0;
    R_addr_B      = '0;
    Wt_addr       = '0;
    Wt_data       = '0;
    L_S           = 1'b0;
    alu_A         = '0;
    alu_B         = '0;
    alu_op        = '0;
    done          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) state_d = S_READ;
      end
      S_READ: begin
        R_addr_A = rs_q;
        R_addr_B = rt_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_A   = op_a_q;
        alu_B   = op_b_q;
        alu_op  = op_q;
        state_d = S_WB;
      end
      S_WB: begin
        // The register file does not protect r0 itself, so the write is dropped here.
        Wt_addr = rd_q;
        Wt_data = res_q;
        L_S     = (rd_q != '0);
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Self-checking bench: external register file and ALU models, a per-cycle reference
// monitor, a directed vector table and a randomized command stream.
module tb_regfile_alu_seq;
  import regfile_alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_alu_seq_if cmd ();
  regfile_alu_seq_if cmd_w ();

  logic [4:0]  r_addr_a, r_addr_b, wt_addr;
  logic [31:0] wt_data, rdata_a, rdata_b, alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        l_s, alu_zero, done, zero_flag;
  logic [15:0] retired_cnt;

  logic [4:0]  w_ra, w_rb, w_wa;
  logic [31:0] w_wd, w_aa, w_ab;
  logic [2:0]  w_op;
  logic        w_ls, w_done, w_zf;
  logic [2:0]  w_cnt;

  regfile_alu_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd(cmd),
    .R_addr_A(r_addr_a), .R_addr_B(r_addr_b), .Wt_addr(wt_addr),
    .Wt_data(wt_data), .L_S(l_s), .rdata_A(rdata_a), .rdata_B(rdata_b),
    .alu_A(alu_a), .alu_B(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .alu_zero(alu_zero), .done(done), .zero_flag(zero_flag),
    .retired_cnt(retired_cnt)
  );

  // Narrow-counter twin fed the same command stream, used to observe counter wrap.
  assign cmd_w.cmd_valid = cmd.cmd_valid;
  assign cmd_w.cmd_op    = cmd.cmd_op;
  assign cmd_w.cmd_li    = cmd.cmd_li;
  assign cmd_w.cmd_imm   = cmd.cmd_imm;
  assign cmd_w.cmd_rs    = cmd.cmd_rs;
  assign cmd_w.cmd_rt    = cmd.cmd_rt;
  assign cmd_w.cmd_rd    = cmd.cmd_rd;

  regfile_alu_seq #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .cmd(cmd_w),
    .R_addr_A(w_ra), .R_addr_B(w_rb), .Wt_addr(w_wa),
    .Wt_data(w_wd), .L_S(w_ls), .rdata_A(32'd0), .rdata_B(32'd0),
    .alu_A(w_aa), .alu_B(w_ab), .alu_op(w_op), .alu_res(32'd0),
    .alu_zero(1'b1), .done(w_done), .zero_flag(w_zf),
    .retired_cnt(w_cnt)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a ^ b;
      3'b100:  return ~(a | b);
      3'b101:  return a >> b[4:0];
      3'b110:  return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // External register file: asynchronous clear on rst, no r0 protection of its own.
  logic [31:0] rf [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (l_s) begin
      rf[wt_addr] <= wt_data;
    end
  end
  assign rdata_a  = rf[r_addr_a];
  assign rdata_b  = rf[r_addr_b];
  assign alu_res  = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_res == 32'd0);

  int assertions = 0;
  int failures   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register values plus a queue of commands in flight.
  typedef struct {
    int          acc;
    logic        li;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, res;
    logic        z;
  } pend_t;

  pend_t       pend_q[$];
  pend_t       ne;
  logic [31:0] model_rf [32];
  int          exp_cnt;
  logic        exp_zero;
  int          cyc = 0;
  int          ph;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend_q.delete();
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      exp_cnt  = 0;
      exp_zero = 1'b0;
    end else begin
      ph = (pend_q.size() != 0) ? (cyc - pend_q[0].acc) : 0;
      if (ph == 0) ne = '{default: '0};
      else ne = pend_q[0];
      checkOutput("cmd_ready",   32'(cmd.cmd_ready), 32'(ph == 0));
      checkOutput("retired_cnt", 32'(retired_cnt), 32'(exp_cnt[15:0]));
      checkOutput("cnt_wrap3",   32'(w_cnt), 32'(exp_cnt[2:0]));
      checkOutput("zero_flag",   32'(zero_flag), 32'(exp_zero));
      checkOutput("R_addr_A", 32'(r_addr_a), (ph == 1) ? 32'(ne.rs) : 32'd0);
      checkOutput("R_addr_B", 32'(r_addr_b), (ph == 1) ? 32'(ne.rt) : 32'd0);
      checkOutput("alu_A",    alu_a, (ph == 2) ? ne.a : 32'd0);
      checkOutput("alu_B",    alu_b, (ph == 2) ? ne.b : 32'd0);
      checkOutput("alu_op",   32'(alu_op), (ph == 2) ? 32'(ne.op) : 32'd0);
      checkOutput("Wt_addr",  32'(wt_addr), (ph == 3) ? 32'(ne.rd) : 32'd0);
      checkOutput("Wt_data",  wt_data, (ph == 3) ? ne.res : 32'd0);
      checkOutput("L_S",      32'(l_s), 32'(ph == 3 && ne.rd != 5'd0));
      checkOutput("done",     32'(done), 32'(ph == 3));
      if (ph >= 3) begin
        void'(pend_q.pop_front());
        exp_cnt++;
        if (!ne.li) exp_zero = ne.z;
      end
      if (cmd.cmd_valid && cmd.cmd_ready) begin
        ne.acc = cyc;
        ne.li  = cmd.cmd_li;
        ne.op  = cmd.cmd_op;
        ne.rs  = cmd.cmd_rs;
        ne.rt  = cmd.cmd_rt;
        ne.rd  = cmd.cmd_rd;
        ne.a   = model_rf[cmd.cmd_rs];
        ne.b   = model_rf[cmd.cmd_rt];
        ne.z   = (alu_f(ne.op, ne.a, ne.b) == 32'd0);
        ne.res = ne.li ? {16'd0, cmd.cmd_imm} : alu_f(ne.op, ne.a, ne.b);
        if (ne.rd != 5'd0) model_rf[ne.rd] = ne.res;
        pend_q.push_back(ne);
      end
    end
  end

  typedef struct {
    logic        li;
    logic [2:0]  op;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [14];

  task automatic waitReady();
    int n = 0;
    while (!cmd.cmd_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd.cmd_ready) checkOutput("ready_timeout", 32'(cmd.cmd_ready), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int exp_count);
    int n = 0;
    waitReady();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_li    = v.li;
    cmd.cmd_op    = v.op;
    cmd.cmd_imm   = v.imm;
    cmd.cmd_rs    = v.rs;
    cmd.cmd_rt    = v.rt;
    cmd.cmd_rd    = v.rd;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_li    = 1'($urandom);
    cmd.cmd_op    = 3'($urandom);
    cmd.cmd_imm   = 16'($urandom);
    cmd.cmd_rs    = 5'($urandom);
    cmd.cmd_rt    = 5'($urandom);
    cmd.cmd_rd    = 5'($urandom);
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checkOutput("done_timeout", 32'(done), 32'd1);
      return;
    end
    checkOutput("vec_wt_addr", 32'(wt_addr), 32'(v.rd));
    checkOutput("vec_wt_data", wt_data, v.exp_data);
    checkOutput("vec_l_s", 32'(l_s), 32'(v.rd != 5'd0));
    @(posedge clk); #1;
    checkOutput("vec_zero_flag", 32'(zero_flag), 32'(v.exp_zero));
    checkOutput("vec_retired", 32'(retired_cnt), 32'(exp_count));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] rdy_mask;
    int          accepts;
    int          ls_seen;

    cmd.cmd_valid = 1'b0;
    cmd.cmd_li    = 1'b0;
    cmd.cmd_op    = 3'd0;
    cmd.cmd_imm   = 16'd0;
    cmd.cmd_rs    = 5'd0;
    cmd.cmd_rt    = 5'd0;
    cmd.cmd_rd    = 5'd0;

    //            li    op      imm       rs     rt     rd      data           zero
    vecs[0]  = '{1'b1, OP_AND, 16'h0005, 5'd0, 5'd0, 5'd1,  32'h0000_0005, 1'b0};
    vecs[1]  = '{1'b1, OP_AND, 16'h0003, 5'd0, 5'd0, 5'd2,  32'h0000_0003, 1'b0};
    vecs[2]  = '{1'b0, OP_ADD, 16'h0000, 5'd1, 5'd2, 5'd3,  32'h0000_0008, 1'b0};
    vecs[3]  = '{1'b0, OP_SUB, 16'h0000, 5'd3, 5'd1, 5'd4,  32'h0000_0003, 1'b0};
    vecs[4]  = '{1'b0, OP_SUB, 16'h0000, 5'd2, 5'd2, 5'd5,  32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, OP_ADD, 16'h0000, 5'd1, 5'd1, 5'd0,  32'h0000_000A, 1'b0};
    vecs[6]  = '{1'b1, OP_AND, 16'hFFFF, 5'd0, 5'd0, 5'd7,  32'h0000_FFFF, 1'b0};
    vecs[7]  = '{1'b0, OP_NOR, 16'h0000, 5'd7, 5'd1, 5'd8,  32'hFFFF_0000, 1'b0};
    vecs[8]  = '{1'b0, OP_SLT, 16'h0000, 5'd8, 5'd1, 5'd9,  32'h0000_0001, 1'b0};
    vecs[9]  = '{1'b0, OP_SRL, 16'h0000, 5'd7, 5'd2, 5'd10, 32'h0000_1FFF, 1'b0};
    vecs[10] = '{1'b0, OP_XOR, 16'h0000, 5'd7, 5'd7, 5'd11, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, OP_AND, 16'h0000, 5'd8, 5'd7, 5'd12, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, OP_ADD, 16'h1234, 5'd1, 5'd2, 5'd14, 32'h0000_1234, 1'b1};
    vecs[13] = '{1'b0, OP_OR,  16'h0000, 5'd1, 5'd2, 5'd13, 32'h0000_0007, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_ready", 32'(cmd.cmd_ready), 32'd1);
    checkOutput("reset_l_s", 32'(l_s), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_cnt", 32'(retired_cnt), 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i + 1);
    checkOutput("r0_stays_zero", rf[0], 32'd0);
    checkOutput("hazard_r4", rf[4], 32'd3);

    $display("[TB] back-pressure: cmd_valid held for 12 cycles");
    waitReady();
    rdy_mask      = '0;
    accepts       = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_li    = 1'b0;
    cmd.cmd_op    = OP_ADD;
    cmd.cmd_rs    = 5'd1;
    cmd.cmd_rt    = 5'd2;
    cmd.cmd_rd    = 5'd15;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cmd.cmd_ready) begin
        rdy_mask[c] = 1'b1;
        accepts++;
      end
      @(posedge clk); #1;
    end
    cmd.cmd_valid = 1'b0;
    checkOutput("bp_accepts", 32'(accepts), 32'd3);
    checkOutput("bp_ready_pattern", 32'(rdy_mask), 32'h0000_0111);
    checkOutput("bp_retired", 32'(retired_cnt), 32'd17);

    $display("[TB] reset during EXEC");
    waitReady();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_li    = 1'b0;
    cmd.cmd_op    = OP_ADD;
    cmd.cmd_rs    = 5'd1;
    cmd.cmd_rt    = 5'd2;
    cmd.cmd_rd    = 5'd6;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("midop_in_exec", 32'(alu_op), 32'(OP_ADD));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midop_ready", 32'(cmd.cmd_ready), 32'd1);
    checkOutput("midop_cnt", 32'(retired_cnt), 32'd0);
    ls_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (l_s) ls_seen++;
    end
    checkOutput("midop_no_write", 32'(ls_seen), 32'd0);
    checkOutput("midop_r6", rf[6], 32'd0);

    $display("[TB] randomized command stream");
    @(posedge clk); #1;
    for (int c = 0; c < 2000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      cmd.cmd_valid = ($urandom_range(0, 3) != 0);
      cmd.cmd_li    = ($urandom_range(0, 3) == 0);
      cmd.cmd_op    = 3'($urandom);
      cmd.cmd_imm   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      cmd.cmd_rs    = 5'($urandom_range(0, 7));
      cmd.cmd_rt    = 5'($urandom_range(0, 7));
      cmd.cmd_rd    = 5'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    rst           = 1'b0;
    cmd.cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) checkOutput("final_regfile", rf[i], model_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
